// File: rtl/route_pkg.sv
// Shared definitions for the route-table lookup: frame delimiters, route word
// layout, FSM state types and the hex/route-word decode helpers.
package route_pkg;

    localparam logic [7:0] STX = 8'h02;
    localparam logic [7:0] ETX = 8'h03;

    localparam int EXIST_BIT = 0;
    localparam int LR_LSB    = 1;
    localparam int UD_LSB    = 3;
    localparam int DROP_LSB  = 5;

    // Field codes: 01 = left/up/drop, 10 = right/down; 00 and 11 mean "none".
    localparam logic [1:0] CODE_A = 2'b01;
    localparam logic [1:0] CODE_B = 2'b10;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_DATA = 2'd1,
        P_END  = 2'd2
    } parse_state_t;

    typedef enum logic {
        L_IDLE = 1'b0,
        L_WAIT = 1'b1
    } lookup_state_t;

    typedef struct packed {
        logic unknown;
        logic left;
        logic right;
        logic up;
        logic down;
        logic drop;
    } route_cmd_t;

    typedef struct packed {
        parse_state_t  pstate;
        lookup_state_t lstate;
    } route_dbg_t;

    // Returns {is_hex, nibble} for an ASCII character.
    function automatic logic [4:0] hex_nibble(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) return {1'b1, b[3:0]};
        if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
            return {1'b1, b[3:0] + 4'd9};
        return 5'd0;
    endfunction

    function automatic route_cmd_t decode_route(input logic [15:0] info);
        route_cmd_t c;
        c         = '0;
        c.unknown = ~info[EXIST_BIT];
        if (info[EXIST_BIT]) begin
            c.left  = (info[LR_LSB+:2]   == CODE_A);
            c.right = (info[LR_LSB+:2]   == CODE_B);
            c.up    = (info[UD_LSB+:2]   == CODE_A);
            c.down  = (info[UD_LSB+:2]   == CODE_B);
            c.drop  = (info[DROP_LSB+:2] == CODE_A);
        end
        return c;
    endfunction

endpackage

// File: rtl/rfid_hex_frame_parser.sv
// Parses STX + 8 ASCII hex chars + ETX into a 32-bit card number; emits a
// registered frame_ok pulse with the card, or a frame_err pulse on bad framing.
module rfid_hex_frame_parser
    import route_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         byte_valid,
    input  logic [7:0]   byte_data,
    output logic         frame_ok,
    output logic [31:0]  card,
    output logic         frame_err,
    output parse_state_t state
);

    parse_state_t state_nxt;
    logic [31:0]  shift_q, shift_nxt;
    logic [2:0]   cnt_q, cnt_nxt;
    logic         ok_nxt, err_nxt;
    logic [4:0]   nib;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= P_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_q   <= shift_nxt;
            cnt_q     <= cnt_nxt;
            frame_ok  <= ok_nxt;
            frame_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_q;
        cnt_nxt   = cnt_q;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        nib       = hex_nibble(byte_data);
        if (byte_valid) begin
            case (state)
                P_IDLE: begin
                    if (byte_data == STX) begin
                        state_nxt = P_DATA;
                        cnt_nxt   = '0;
                    end
                end
                P_DATA: begin
                    // STX restarts the frame; ETX and other non-hex bytes abort it.
                    if (byte_data == STX) begin
                        cnt_nxt = '0;
                        err_nxt = 1'b1;
                    end else if (nib[4]) begin
                        shift_nxt = {shift_q[27:0], nib[3:0]};
                        cnt_nxt   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) state_nxt = P_END;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = P_IDLE;
                    end
                end
                P_END: begin
                    if (byte_data == ETX) begin
                        ok_nxt    = 1'b1;
                        state_nxt = P_IDLE;
                    end else if (byte_data == STX) begin
                        err_nxt   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = P_DATA;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = P_IDLE;
                    end
                end
                default: state_nxt = P_IDLE;
            endcase
        end
    end

    assign card = shift_q;

endmodule

// File: rtl/rfid_route_client.sv
// Requester side of the route-table lookup: one lookup per parsed card, with
// duplicate holdoff, lookup timeout and latched decode of the returned route word.
module rfid_route_client
    import route_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int HOLDOFF_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        start,
    output logic [31:0] rfid_data,
    input  logic        done,
    input  logic [15:0] rfid_info,
    output logic        busy,
    output logic        route_valid,
    output logic        dir_left,
    output logic        dir_right,
    output logic        dir_up,
    output logic        dir_down,
    output logic        drop,
    output logic        unknown_card,
    output logic        timeout_err,
    output logic        frame_err,
    output route_dbg_t  dbg
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HO_W = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF_CYCLES);

    logic          frame_ok, parse_err;
    logic [31:0]   card;
    parse_state_t  pstate;
    lookup_state_t lstate, lstate_nxt;

    logic [TO_W-1:0] wait_cnt;
    logic [HO_W-1:0] holdoff_cnt;
    logic [31:0]     last_card;
    logic            last_card_vld;
    route_cmd_t      cmd;
    logic            drop_err;
    logic            launch, complete, expire, drop_busy, dup;

    rfid_hex_frame_parser u_parser (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_ok   (frame_ok),
        .card       (card),
        .frame_err  (parse_err),
        .state      (pstate)
    );

    assign dup = last_card_vld && (card == last_card) && (holdoff_cnt != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lstate <= L_IDLE;
        else        lstate <= lstate_nxt;
    end

    always_comb begin
        lstate_nxt = lstate;
        launch     = 1'b0;
        complete   = 1'b0;
        expire     = 1'b0;
        drop_busy  = 1'b0;
        case (lstate)
            L_IDLE: begin
                if (frame_ok && !dup) begin
                    launch     = 1'b1;
                    lstate_nxt = L_WAIT;
                end
            end
            L_WAIT: begin
                drop_busy = frame_ok;
                // done in the final counted cycle still completes the lookup.
                if (done) begin
                    complete   = 1'b1;
                    lstate_nxt = L_IDLE;
                end else if (wait_cnt == TO_LAST) begin
                    expire     = 1'b1;
                    lstate_nxt = L_IDLE;
                end
            end
            default: lstate_nxt = L_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start         <= 1'b0;
            rfid_data     <= '0;
            wait_cnt      <= '0;
            holdoff_cnt   <= '0;
            last_card     <= '0;
            last_card_vld <= 1'b0;
            cmd           <= '0;
            route_valid   <= 1'b0;
            timeout_err   <= 1'b0;
            drop_err      <= 1'b0;
        end else begin
            start       <= launch;
            route_valid <= complete;
            timeout_err <= expire;
            drop_err    <= drop_busy;
            if (launch) begin
                rfid_data <= card;
                wait_cnt  <= '0;
            end else if (lstate == L_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (complete) begin
                cmd           <= decode_route(rfid_info);
                last_card     <= rfid_data;
                last_card_vld <= 1'b1;
                holdoff_cnt   <= HO_LOAD;
            end else if (holdoff_cnt != '0) begin
                holdoff_cnt <= holdoff_cnt - 1'b1;
            end
        end
    end

    assign busy         = (lstate == L_WAIT);
    assign frame_err    = parse_err | drop_err;
    assign unknown_card = cmd.unknown;
    assign dir_left     = cmd.left;
    assign dir_right    = cmd.right;
    assign dir_up       = cmd.up;
    assign dir_down     = cmd.down;
    assign drop         = cmd.drop;
    assign dbg          = '{pstate: pstate, lstate: lstate};

endmodule

// File: tb/tb_rfid_route_client.sv
// Bench for rfid_route_client: drives reader byte streams, answers lookups
// from a route-table responder and checks against a frame/holdoff/decode model.
module tb_rfid_route_client;
    import route_pkg::*;

    localparam int TO = 64;
    localparam int HO = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        done = 1'b0;
    logic [15:0] rfid_info = 16'h0000;
    logic        start, busy, route_valid, timeout_err, frame_err;
    logic        dir_left, dir_right, dir_up, dir_down, drop, unknown_card;
    logic [31:0] rfid_data;
    route_dbg_t  dbg;

    rfid_route_client #(.TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(HO)) dut (
        .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
        .start(start), .rfid_data(rfid_data), .done(done), .rfid_info(rfid_info),
        .busy(busy), .route_valid(route_valid), .dir_left(dir_left),
        .dir_right(dir_right), .dir_up(dir_up), .dir_down(dir_down), .drop(drop),
        .unknown_card(unknown_card), .timeout_err(timeout_err),
        .frame_err(frame_err), .dbg(dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // event monitor, sampled on the falling edge
    int start_cnt = 0, start_cyc = 0, rv_cnt = 0, rv_cyc = 0;
    int to_cnt = 0, to_cyc = 0, fe_cnt = 0;
    always @(negedge clk) begin
        if (start)       begin start_cnt++; start_cyc = cyc; end
        if (route_valid) begin rv_cnt++;    rv_cyc = cyc;    end
        if (timeout_err) begin to_cnt++;    to_cyc = cyc;    end
        if (frame_err)   fe_cnt++;
    end

    // route-table responder: done resp_delay cycles after start
    bit          resp_en = 1'b0;
    int          resp_delay = 3;
    logic [15:0] resp_info = 16'h0000;
    initial forever begin
        @(negedge clk);
        if (start && resp_en) begin
            repeat (resp_delay) @(negedge clk);
            done = 1'b1;
            rfid_info = resp_info;
            @(negedge clk);
            done = 1'b0;
        end
    end

    // reference model
    logic [31:0] m_last = 32'h0;
    bit          m_vld = 1'b0;
    int          m_done_cyc = 0;
    logic [5:0]  m_cmd = 6'b0;   // {unknown, left, right, up, down, drop}

    function automatic logic [5:0] model_decode(input logic [15:0] info);
        int lr, ud, dr;
        if (info % 2 == 0) return 6'b100000;
        lr = (info / 2) % 4;
        ud = (info / 8) % 4;
        dr = (info / 32) % 4;
        return {1'b0, lr == 1, lr == 2, ud == 1, ud == 2, dr == 1};
    endfunction

    // A frame completing at cycle f repeats the last card inside the holdoff
    // window if it is within HO cycles after the done cycle.
    function automatic bit model_dup(input logic [31:0] c, input int f);
        return m_vld && (c == m_last) && (f - m_done_cyc <= HO);
    endfunction

    function automatic void model_complete(input logic [31:0] c, input int f,
                                           input int d, input logic [15:0] info);
        m_last     = c;
        m_vld      = 1'b1;
        m_done_cyc = f + 1 + d;
        m_cmd      = model_decode(info);
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n, input bit lower);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return (lower ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
    endfunction

    wire [5:0] obs_cmd = {unknown_card, dir_left, dir_right, dir_up, dir_down, drop};

    // drivers (all called on a falling edge)
    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_frame(input logic [31:0] c, input bit lower);
        send_byte(STX);
        for (int i = 7; i >= 0; i--) send_byte(hex_char(c[i*4+:4], lower));
        send_byte(ETX);
    endtask

    int d_start, d_rv, d_to, d_fe, lat, to_lat, f_cyc;

    task automatic lookup(input logic [31:0] c, input bit lower, input bit respond,
                          input int delay, input logic [15:0] info, input int wait_cyc);
        int s0, r0, t0, e0;
        s0 = start_cnt; r0 = rv_cnt; t0 = to_cnt; e0 = fe_cnt;
        resp_en = respond; resp_delay = delay; resp_info = info;
        send_frame(c, lower);
        f_cyc = cyc;
        repeat (wait_cyc) @(negedge clk);
        d_start = start_cnt - s0;
        d_rv    = rv_cnt - r0;
        d_to    = to_cnt - t0;
        d_fe    = fe_cnt - e0;
        lat     = (d_rv != 0) ? rv_cyc - start_cyc : -1;
        to_lat  = (d_to != 0) ? to_cyc - start_cyc : -1;
    endtask

    // tests
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (start !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL reset_start_busy got %b%b exp 00", start, busy); end
        checks++; if (rfid_data !== 32'h0) begin errors++;
            $display("FAIL reset_rfid_data got %h exp 0", rfid_data); end
        checks++; if (obs_cmd !== 6'b0) begin errors++;
            $display("FAIL reset_cmd got %b exp 000000", obs_cmd); end
        checks++; if ({route_valid, timeout_err, frame_err} !== 3'b0) begin errors++;
            $display("FAIL reset_pulses got %b exp 000", {route_valid, timeout_err, frame_err}); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        lookup(32'hC4243351, 1'b0, 1'b1, 3, 16'h0003, 12);
        checks++; if (d_start !== 1) begin errors++;
            $display("FAIL basic_start_count got %0d exp 1", d_start); end
        checks++; if (start_cyc !== f_cyc + 1) begin errors++;
            $display("FAIL basic_start_timing got %0d exp %0d", start_cyc, f_cyc + 1); end
        checks++; if (rfid_data !== 32'hC4243351) begin errors++;
            $display("FAIL basic_rfid_data got %h exp C4243351", rfid_data); end
        checks++; if (lat !== 4) begin errors++;
            $display("FAIL basic_latency got %0d exp 4", lat); end
        model_complete(32'hC4243351, f_cyc, 3, 16'h0003);
        checks++; if (obs_cmd !== m_cmd) begin errors++;
            $display("FAIL basic_decode got %b exp %b", obs_cmd, m_cmd); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL basic_busy got %b exp 0", busy); end
    endtask

    task automatic test_holdoff();
        bit exp;
        lookup(32'hC4243351, 1'b0, 1'b1, 3, 16'h0003, 12);
        exp = !model_dup(32'hC4243351, f_cyc);
        checks++; if (d_start !== int'(exp) || d_fe !== 0) begin errors++;
            $display("FAIL holdoff_dup got start %0d err %0d exp start %0d err 0", d_start, d_fe, exp); end
        repeat (HO + 10) @(negedge clk);
        lookup(32'hC4243351, 1'b0, 1'b1, 2, 16'h0003, 12);
        exp = !model_dup(32'hC4243351, f_cyc);
        checks++; if (d_start !== int'(exp)) begin errors++;
            $display("FAIL holdoff_expired got start %0d exp %0d", d_start, exp); end
        if (exp) model_complete(32'hC4243351, f_cyc, 2, 16'h0003);
        lookup(32'h0E8A3E4E, 1'b1, 1'b1, 2, 16'h0009, 12);
        checks++; if (rfid_data !== 32'h0E8A3E4E) begin errors++;
            $display("FAIL lower_rfid_data got %h exp 0E8A3E4E", rfid_data); end
        model_complete(32'h0E8A3E4E, f_cyc, 2, 16'h0009);
        checks++; if (obs_cmd !== m_cmd) begin errors++;
            $display("FAIL lower_decode got %b exp %b", obs_cmd, m_cmd); end
    endtask

    task automatic test_malformed();
        int s0, e0;
        resp_en = 1'b1; resp_delay = 2; resp_info = 16'h0003;
        s0 = start_cnt; e0 = fe_cnt;
        send_byte(STX); send_str("C4G"); repeat (4) @(negedge clk);
        checks++; if (fe_cnt - e0 !== 1 || start_cnt - s0 !== 0) begin errors++;
            $display("FAIL bad_hex got err %0d start %0d exp 1 0", fe_cnt - e0, start_cnt - s0); end
        e0 = fe_cnt;
        send_byte(STX); send_str("12345"); send_byte(ETX); repeat (4) @(negedge clk);
        checks++; if (fe_cnt - e0 !== 1) begin errors++;
            $display("FAIL short_frame got err %0d exp 1", fe_cnt - e0); end
        e0 = fe_cnt;
        send_byte(STX); send_str("89ABCDEFX"); repeat (4) @(negedge clk);
        checks++; if (fe_cnt - e0 !== 1 || start_cnt - s0 !== 0) begin errors++;
            $display("FAIL bad_end got err %0d start %0d exp 1 0", fe_cnt - e0, start_cnt - s0); end
        e0 = fe_cnt;
        send_byte(STX); send_str("AB");
        lookup(32'h13572468, 1'b0, 1'b1, 2, 16'h0011, 12);
        checks++; if (fe_cnt - e0 !== 1 || d_start !== 1) begin errors++;
            $display("FAIL restart got err %0d start %0d exp 1 1", fe_cnt - e0, d_start); end
        checks++; if (rfid_data !== 32'h13572468) begin errors++;
            $display("FAIL restart_rfid_data got %h exp 13572468", rfid_data); end
        model_complete(32'h13572468, f_cyc, 2, 16'h0011);
    endtask

    task automatic test_timeout();
        lookup(32'hDEAD0001, 1'b0, 1'b0, 0, 16'h0000, 80);
        checks++; if (d_start !== 1 || d_to !== 1 || d_rv !== 0) begin errors++;
            $display("FAIL timeout_events got s%0d t%0d r%0d exp s1 t1 r0", d_start, d_to, d_rv); end
        checks++; if (to_lat !== TO) begin errors++;
            $display("FAIL timeout_latency got %0d exp %0d", to_lat, TO); end
        checks++; if (busy !== 1'b0 || obs_cmd !== m_cmd) begin errors++;
            $display("FAIL timeout_state got busy %b cmd %b exp 0 %b", busy, obs_cmd, m_cmd); end
        // resend: no holdoff on a timed-out card; done in the last cycle wins
        lookup(32'hDEAD0001, 1'b0, 1'b1, TO - 1, 16'h0025, 80);
        checks++; if (d_start !== 1 || d_rv !== 1 || d_to !== 0) begin errors++;
            $display("FAIL late_done got s%0d r%0d t%0d exp s1 r1 t0", d_start, d_rv, d_to); end
        checks++; if (lat !== TO) begin errors++;
            $display("FAIL late_done_latency got %0d exp %0d", lat, TO); end
        model_complete(32'hDEAD0001, f_cyc, TO - 1, 16'h0025);
        checks++; if (obs_cmd !== m_cmd) begin errors++;
            $display("FAIL right_drop_decode got %b exp %b", obs_cmd, m_cmd); end
    endtask

    task automatic test_busy_drop();
        int s0, e0, fa;
        s0 = start_cnt; e0 = fe_cnt;
        resp_en = 1'b1; resp_delay = 40; resp_info = 16'h0027;
        send_frame(32'h0BADF00D, 1'b0);
        fa = cyc;
        send_frame(32'h0000BEEF, 1'b1);
        repeat (50) @(negedge clk);
        checks++; if (start_cnt - s0 !== 1 || fe_cnt - e0 !== 1) begin errors++;
            $display("FAIL busy_drop got start %0d err %0d exp 1 1", start_cnt - s0, fe_cnt - e0); end
        checks++; if (rfid_data !== 32'h0BADF00D) begin errors++;
            $display("FAIL busy_drop_data got %h exp 0BADF00D", rfid_data); end
        model_complete(32'h0BADF00D, fa, 40, 16'h0027);
        checks++; if (obs_cmd !== m_cmd) begin errors++;
            $display("FAIL code11_decode got %b exp %b", obs_cmd, m_cmd); end
        lookup(32'h55AA55AA, 1'b0, 1'b1, 1, 16'h0000, 10);
        model_complete(32'h55AA55AA, f_cyc, 1, 16'h0000);
        checks++; if (obs_cmd !== m_cmd) begin errors++;
            $display("FAIL unknown_decode got %b exp %b", obs_cmd, m_cmd); end
    endtask

    task automatic test_random();
        logic [31:0] c, prev;
        logic [15:0] info;
        int d;
        bit exp;
        prev = m_last;
        for (int i = 0; i < 24; i++) begin
            c    = (i % 4 == 3) ? prev : $urandom;
            d    = $urandom_range(0, 20);
            info = 16'($urandom_range(0, 16'hFFFF));
            lookup(c, 1'($urandom_range(0, 1)), 1'b1, d, info, 30);
            exp = !model_dup(c, f_cyc);
            checks++; if (d_start !== int'(exp) || d_rv !== int'(exp)) begin errors++;
                $display("FAIL rand_%0d_events got s%0d r%0d exp %0d", i, d_start, d_rv, exp); end
            if (exp) begin
                model_complete(c, f_cyc, d, info);
                checks++; if (rfid_data !== c || lat !== d + 1) begin errors++;
                    $display("FAIL rand_%0d_lookup got %h lat %0d exp %h lat %0d", i, rfid_data, lat, c, d + 1); end
            end
            checks++; if (obs_cmd !== m_cmd) begin errors++;
                $display("FAIL rand_%0d_decode got %b exp %b", i, obs_cmd, m_cmd); end
            prev = c;
        end
    endtask

    task automatic test_reset_in_wait();
        int r0;
        lookup(32'h0C0FFEE0, 1'b0, 1'b1, 2, 16'h0003, 10);
        model_complete(32'h0C0FFEE0, f_cyc, 2, 16'h0003);
        r0 = rv_cnt;
        resp_en = 1'b1; resp_delay = 10; resp_info = 16'h0011;
        send_frame(32'hFACE0FF0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({start, busy} !== 2'b00 || rfid_data !== 32'h0) begin errors++;
            $display("FAIL wait_reset_req got %b%b %h exp 00 0", start, busy, rfid_data); end
        checks++; if (obs_cmd !== 6'b0) begin errors++;
            $display("FAIL wait_reset_cmd got %b exp 000000", obs_cmd); end
        @(negedge clk);
        reset = 1'b1;
        m_vld = 1'b0; m_cmd = 6'b0; m_last = 32'h0;
        repeat (20) @(negedge clk);
        checks++; if (rv_cnt - r0 !== 0 || busy !== 1'b0 || obs_cmd !== m_cmd) begin errors++;
            $display("FAIL stray_done got rv %0d busy %b cmd %b exp 0 0 %b", rv_cnt - r0, busy, obs_cmd, m_cmd); end
        lookup(32'h0C0FFEE0, 1'b0, 1'b1, 2, 16'h0003, 10);
        checks++; if (d_start !== 1) begin errors++;
            $display("FAIL post_reset_lookup got %0d exp 1", d_start); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_holdoff();
        test_malformed();
        test_timeout();
        test_busy_drop();
        test_random();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
